memory_stage: RTL
=================

Name: memory_stage

Overview:
- Pipeline stage between Execute and Writeback of the RV32I core.
- Issues loads and stores to the data-memory port through a req/gnt/rvalid handshake.
- Aligns and sign-extends load data; builds store byte-enables.
- Passes non-memory results through, and stalls Execute while a memory transaction is outstanding.
- Its outputs drive Writeback's i_rd, i_opcode, i_wb_data and i_mem_vld.

Parameters:
- N, 32, datapath and address width. The shared `N define sets the default.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_ex_vld  in  1  Execute has a valid instruction this cycle
- i_rd  in  5  destination register
- i_opcode  in  7  instruction opcode
- i_funct3  in  3  load/store size and sign selector
- i_alu_result  in  N  ALU result; the effective address for loads and stores
- i_rs2_data  in  N  store data
- o_ex_stall  out  1  Execute must hold its outputs
- o_dmem_req  out  1  memory request
- o_dmem_we  out  1  1 = store, 0 = load
- o_dmem_addr  out  N  word-aligned address {addr[N-1:2],2'b00}
- o_dmem_wdata  out  N  lane-replicated store data
- o_dmem_be  out  4  byte enables
- i_dmem_gnt  in  1  request accepted
- i_dmem_rvalid  in  1  load data valid
- i_dmem_rdata  in  N  load data word
- o_rd  out  5  to Writeback
- o_opcode  out  7  to Writeback
- o_wb_data  out  N  to Writeback
- o_mem_vld  out  1  to Writeback; one-cycle pulse per retired instruction
- o_misaligned  out  1  qualifies o_mem_vld: the access was misaligned or illegal

Behaviour:
- Reset: state=IDLE; all outputs are 0 and all output registers clear asynchronously. Reset during REQ or WAIT_RSP abandons the transaction, and o_dmem_req drops immediately.
- FSM states: IDLE, REQ, WAIT_RSP. o_ex_stall = (state != IDLE).
- IDLE with i_ex_vld and a non-memory opcode:
  - Next cycle: o_mem_vld=1, o_rd=i_rd, o_opcode=i_opcode, o_wb_data=i_alu_result.
  - Latency is 1 cycle, with back-to-back throughput.
- IDLE with i_ex_vld and opcode `L or `S:
  - Check alignment: LW/SW need addr[1:0]=0; LH/LHU/SH need addr[0]=0.
  - Illegal funct3 values are: loads 011/110/111, stores 011 and above.
  - If misaligned or illegal: no request is issued. Next cycle o_mem_vld=1, o_misaligned=1, o_rd=0, o_wb_data=0, and the state stays IDLE.
  - Otherwise: capture rd, opcode, funct3, addr[1:0] and store data, then go to REQ.
- REQ:
  - o_dmem_req=1 with addr, we, be and wdata held stable until i_dmem_gnt.
  - Store + gnt: next cycle o_mem_vld=1, o_wb_data=0, and the state returns to IDLE.
  - Load + gnt: go to WAIT_RSP.
- WAIT_RSP:
  - On i_dmem_rvalid: format the data, pulse o_mem_vld with o_wb_data for 1 cycle, then go to IDLE.
  - rvalid never arrives in the gnt cycle; if it does, it is ignored.
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: be=4'b0011<<addr[1:0], wdata={2{rs2[15:0]}}.
  - SW: be=4'b1111.
  - Loads drive be=4'b1111 and we=0.
- Load formatting (byte/half selected by the captured addr[1:0]):
  - LB: sign-extend byte. LBU: zero-extend byte.
  - LH: sign-extend half. LHU: zero-extend half.
  - LW: full word.
- Outputs other than o_mem_vld and o_misaligned hold their last value when o_mem_vld=0.
- Minimum load latency from the IDLE accept is 3 cycles (accept→REQ→gnt→rvalid→vld).
- The memory must not issue rvalid for a transaction that was abandoned by reset.

Decomposition:
- The shared defines file holds `N, the opcodes `L=7'b0000011, `S=7'b0100011 and `B, and the funct3 encodings for LB/LH/LW/LBU/LHU/SB/SH/SW.
- One combinational sub-module, mem_load_align: inputs rdata, addr[1:0], funct3; output the formatted N-bit load value. The store lane logic stays inline.

Test Plan:
- ADD result 0x1234, rd=5, in IDLE → next cycle o_mem_vld=1, o_rd=5, o_wb_data=0x1234, o_ex_stall=0. Two back-to-back ALU ops retire on consecutive cycles.
- SB rs2=0x000000AB, addr=0x1003, gnt delayed 2 cycles → req held 3 cycles with addr=0x1000, be=4'b1000, wdata=0xABABABAB. Then one o_mem_vld pulse; stall is high throughout.
- LB addr=0x2002, rdata=0x00F40000 (byte=0xF4) → o_wb_data=0xFFFFFFF4. LBU at the same address → 0x000000F4. LH addr=0x2002, rdata=0x80010000 → 0xFFFF8001.
- LW addr=0x3001 → no o_dmem_req. Next cycle o_mem_vld=1, o_misaligned=1, o_rd=0. The same applies to SH at 0x3003.
- Assert rst_n=0 while in WAIT_RSP → o_dmem_req and o_mem_vld go 0 immediately, the state goes to IDLE, and after release an ALU op retires normally.
- LW with gnt and rvalid both asserted in the same REQ cycle → that rvalid is ignored, and the data is taken from the next rvalid.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// ============================================================================
// memory_stage_pkg
// Shared RV32I memory-stage defines, FSM state type and access-legality helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef MEMORY_STAGE_DEFINES
`define MEMORY_STAGE_DEFINES
`define N      32
`define L      7'b0000011
`define S      7'b0100011
`define B      7'b1100011
`define F3_LB  3'b000
`define F3_LH  3'b001
`define F3_LW  3'b010
`define F3_LBU 3'b100
`define F3_LHU 3'b101
`define F3_SB  3'b000
`define F3_SH  3'b001
`define F3_SW  3'b010
`endif

package memory_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2
    } state_e;

    localparam logic [6:0] OPC_LOAD  = `L;
    localparam logic [6:0] OPC_STORE = `S;

    localparam logic [2:0] F3_LB  = `F3_LB;
    localparam logic [2:0] F3_LH  = `F3_LH;
    localparam logic [2:0] F3_LW  = `F3_LW;
    localparam logic [2:0] F3_LBU = `F3_LBU;
    localparam logic [2:0] F3_LHU = `F3_LHU;
    localparam logic [2:0] F3_SB  = `F3_SB;
    localparam logic [2:0] F3_SH  = `F3_SH;
    localparam logic [2:0] F3_SW  = `F3_SW;

    // True when the access must be refused: unknown size encoding or misaligned address.
    function automatic logic access_bad(input logic       is_store,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
        logic illegal;
        logic misaligned;
        if (is_store)
            illegal = (funct3 >= 3'b011);
        else
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        misaligned = ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00)) ||
                     ((funct3[1:0] == 2'b01) && addr_lo[0]);
        return illegal || misaligned;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_load_align.sv
// ============================================================================
// mem_load_align
// Selects the addressed byte/half of a load word and sign- or zero-extends it.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_load_align
    import memory_stage_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] i_rdata,
    input  logic [1:0]   i_addr_lo,
    input  logic [2:0]   i_funct3,
    output logic [N-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        o_data = i_rdata;
        case (i_funct3)
            F3_LB:   o_data = {{(N-8){w_byte[7]}}, w_byte};
            F3_LBU:  o_data = {{(N-8){1'b0}}, w_byte};
            F3_LH:   o_data = {{(N-16){w_half[15]}}, w_half};
            F3_LHU:  o_data = {{(N-16){1'b0}}, w_half};
            F3_LW:   o_data = i_rdata;
            default: o_data = i_rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/memory_stage.sv
// ============================================================================
// memory_stage
// RV32I Memory stage: issues data-memory transactions, formats loads, retires to Writeback.
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef N
`define N 32
`endif

module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int N = `N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_ex_vld,
    input  logic [4:0]   i_rd,
    input  logic [6:0]   i_opcode,
    input  logic [2:0]   i_funct3,
    input  logic [N-1:0] i_alu_result,
    input  logic [N-1:0] i_rs2_data,
    output logic         o_ex_stall,
    output logic         o_dmem_req,
    output logic         o_dmem_we,
    output logic [N-1:0] o_dmem_addr,
    output logic [N-1:0] o_dmem_wdata,
    output logic [3:0]   o_dmem_be,
    input  logic         i_dmem_gnt,
    input  logic         i_dmem_rvalid,
    input  logic [N-1:0] i_dmem_rdata,
    output logic [4:0]   o_rd,
    output logic [6:0]   o_opcode,
    output logic [N-1:0] o_wb_data,
    output logic         o_mem_vld,
    output logic         o_misaligned
);

    state_e         state_q, state_d;
    logic [4:0]     rd_q, rd_d;
    logic [6:0]     op_q, op_d;
    logic [2:0]     f3_q, f3_d;
    logic [1:0]     off_q, off_d;
    logic           we_q, we_d;
    logic [N-1:0]   addr_q, addr_d;
    logic [N-1:0]   wdata_q, wdata_d;
    logic [3:0]     be_q, be_d;
    logic [4:0]     out_rd_q, out_rd_d;
    logic [6:0]     out_op_q, out_op_d;
    logic [N-1:0]   wb_q, wb_d;
    logic           vld_q, vld_d;
    logic           mis_q, mis_d;

    logic [N-1:0]   w_load_data;
    logic           w_is_load;
    logic           w_is_store;

    mem_load_align #(.N(N)) u_load_align (
        .i_rdata   (i_dmem_rdata),
        .i_addr_lo (off_q),
        .i_funct3  (f3_q),
        .o_data    (w_load_data)
    );

    assign w_is_load  = (i_opcode == OPC_LOAD);
    assign w_is_store = (i_opcode == OPC_STORE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rd_q     <= '0;
            op_q     <= '0;
            f3_q     <= '0;
            off_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            out_rd_q <= '0;
            out_op_q <= '0;
            wb_q     <= '0;
            vld_q    <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            op_q     <= op_d;
            f3_q     <= f3_d;
            off_q    <= off_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            out_rd_q <= out_rd_d;
            out_op_q <= out_op_d;
            wb_q     <= wb_d;
            vld_q    <= vld_d;
            mis_q    <= mis_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        op_d     = op_q;
        f3_d     = f3_q;
        off_d    = off_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        out_rd_d = out_rd_q;
        out_op_d = out_op_q;
        wb_d     = wb_q;
        vld_d    = 1'b0;
        mis_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_ex_vld) begin
                    if (w_is_load || w_is_store) begin
                        if (access_bad(w_is_store, i_funct3, i_alu_result[1:0])) begin
                            vld_d    = 1'b1;
                            mis_d    = 1'b1;
                            out_rd_d = '0;
                            out_op_d = i_opcode;
                            wb_d     = '0;
                        end else begin
                            rd_d    = i_rd;
                            op_d    = i_opcode;
                            f3_d    = i_funct3;
                            off_d   = i_alu_result[1:0];
                            we_d    = w_is_store;
                            addr_d  = {i_alu_result[N-1:2], 2'b00};
                            wdata_d = i_rs2_data;
                            be_d    = 4'b1111;
                            // Store lanes are built once here so the bus stays stable while waiting for gnt.
                            if (w_is_store) begin
                                case (i_funct3)
                                    F3_SB: begin
                                        be_d    = 4'b0001 << i_alu_result[1:0];
                                        wdata_d = {4{i_rs2_data[7:0]}};
                                    end
                                    F3_SH: begin
                                        be_d    = 4'b0011 << i_alu_result[1:0];
                                        wdata_d = {2{i_rs2_data[15:0]}};
                                    end
                                    F3_SW:   be_d = 4'b1111;
                                    default: be_d = 4'b1111;
                                endcase
                            end
                            state_d = ST_REQ;
                        end
                    end else begin
                        vld_d    = 1'b1;
                        out_rd_d = i_rd;
                        out_op_d = i_opcode;
                        wb_d     = i_alu_result;
                    end
                end
            end
            ST_REQ: begin
                if (i_dmem_gnt) begin
                    if (we_q) begin
                        vld_d    = 1'b1;
                        out_rd_d = rd_q;
                        out_op_d = op_q;
                        wb_d     = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_RSP;
                    end
                end
            end
            ST_WAIT_RSP: begin
                if (i_dmem_rvalid) begin
                    vld_d    = 1'b1;
                    out_rd_d = rd_q;
                    out_op_d = op_q;
                    wb_d     = w_load_data;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_ex_stall   = (state_q != ST_IDLE);
    assign o_dmem_req   = (state_q == ST_REQ);
    assign o_dmem_we    = we_q;
    assign o_dmem_addr  = addr_q;
    assign o_dmem_wdata = wdata_q;
    assign o_dmem_be    = be_q;
    assign o_rd         = out_rd_q;
    assign o_opcode     = out_op_q;
    assign o_wb_data    = wb_q;
    assign o_mem_vld    = vld_q;
    assign o_misaligned = mis_q;

endmodule

`default_nettype wire
